cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_pkg.sv | 12 +
 rtl/cache_controller_sat_counter.sv | 16 +
 rtl/cache_controller.sv | 132 +++++++++++++
 tb/tb_cache_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and sizes for the write-through cache controller.
package cache_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
    localparam int          CACHE_ADDR_W      = 17;
    localparam int          LINE_W            = 64;
endpackage

// File: rtl/cache_controller_sat_counter.sv
// Saturating up-counter used for hit/miss statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate cache controller between CPU, cache array and SRAM.
module cache_controller
    import cache_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int          CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MEM_R_EN,
    input  logic                    MEM_W_EN,
    input  logic [31:0]             address,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    output logic                    ready,
    output logic [CACHE_ADDR_W-1:0] cache_address,
    output logic [LINE_W-1:0]       cache_wdata,
    output logic                    cache_we,
    output logic                    cache_re,
    output logic                    cache_invalidate,
    input  logic                    cache_hit,
    input  logic [31:0]             cache_rdata,
    output logic [31:0]             sram_address,
    output logic [31:0]             sram_wdata,
    output logic                    sram_re,
    output logic                    sram_we,
    input  logic [LINE_W-1:0]       sram_rdata,
    input  logic                    sram_ready,
    output logic [CNT_W-1:0]        hit_count,
    output logic [CNT_W-1:0]        miss_count
);
    state_t      state, state_nxt;
    logic [31:0] addr_q, data_q;
    logic        latch_addr, latch_data;
    logic        hit_inc, miss_inc;
    logic [31:0] offset;
    logic        unused_offset_bits;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            if (latch_addr) addr_q <= address;
            if (latch_data) data_q <= wdata;
        end
    end

    // Live address while idle so a hit can be looked up with zero stall.
    assign offset             = ((state == IDLE) ? address : addr_q) - BASE_ADDR;
    assign cache_address      = offset[18:2];
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    always_comb begin
        state_nxt        = state;
        ready            = 1'b1;
        rdata            = '0;
        cache_we         = 1'b0;
        cache_re         = 1'b0;
        cache_invalidate = 1'b0;
        cache_wdata      = '0;
        sram_address     = '0;
        sram_wdata       = '0;
        sram_re          = 1'b0;
        sram_we          = 1'b0;
        latch_addr       = 1'b0;
        latch_data       = 1'b0;
        hit_inc          = 1'b0;
        miss_inc         = 1'b0;
        // Outputs stay quiet while reset is asserted, whatever the state register holds.
        if (rst) begin
            case (state)
                IDLE: begin
                    if (MEM_W_EN) begin
                        cache_invalidate = 1'b1;
                        latch_addr       = 1'b1;
                        latch_data       = 1'b1;
                        ready            = 1'b0;
                        state_nxt        = WRITE;
                    end else if (MEM_R_EN) begin
                        if (cache_hit) begin
                            cache_re = 1'b1;
                            rdata    = cache_rdata;
                            hit_inc  = 1'b1;
                        end else begin
                            latch_addr = 1'b1;
                            miss_inc   = 1'b1;
                            ready      = 1'b0;
                            state_nxt  = FILL;
                        end
                    end
                end
                FILL: begin
                    sram_re      = 1'b1;
                    sram_address = addr_q;
                    ready        = 1'b0;
                    if (sram_ready) begin
                        cache_we    = 1'b1;
                        cache_wdata = sram_rdata;
                        rdata       = addr_q[2] ? sram_rdata[LINE_W-1:32] : sram_rdata[31:0];
                        ready       = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
                WRITE: begin
                    sram_we      = 1'b1;
                    sram_address = addr_q;
                    sram_wdata   = data_q;
                    ready        = sram_ready;
                    if (sram_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: the bench plays CPU, cache array and SRAM against a transaction-level model.
module tb_cache_controller;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
    logic [31:0] address = '0, wdata = '0;
    logic        cache_hit = 1'b0;
    logic [31:0] cache_rdata = '0;
    logic [63:0] sram_rdata = '0;
    logic        sram_ready = 1'b0;

    logic [31:0] rdata, sram_address, sram_wdata;
    logic        ready, cache_we, cache_re, cache_invalidate, sram_re, sram_we;
    logic [16:0] cache_address;
    logic [63:0] cache_wdata;
    logic [15:0] hit_count, miss_count;

    logic [31:0] rdata_2, sram_address_2, sram_wdata_2;
    logic        ready_2, cache_we_2, cache_re_2, cache_invalidate_2, sram_re_2, sram_we_2;
    logic [16:0] cache_address_2;
    logic [63:0] cache_wdata_2;
    logic [1:0]  hit_count_2, miss_count_2;

    int          n_chk = 0, n_fail = 0;
    int unsigned m_hits = 0, m_miss = 0;

    wire [5:0] strb = {ready, cache_re, cache_we, cache_invalidate, sram_re, sram_we};

    cache_controller dut (
        .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .cache_address(cache_address), .cache_wdata(cache_wdata), .cache_we(cache_we),
        .cache_re(cache_re), .cache_invalidate(cache_invalidate), .cache_hit(cache_hit),
        .cache_rdata(cache_rdata), .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_re(sram_re), .sram_we(sram_we), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_controller #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .address(address), .wdata(wdata), .rdata(rdata_2), .ready(ready_2),
        .cache_address(cache_address_2), .cache_wdata(cache_wdata_2), .cache_we(cache_we_2),
        .cache_re(cache_re_2), .cache_invalidate(cache_invalidate_2), .cache_hit(cache_hit),
        .cache_rdata(cache_rdata), .sram_address(sram_address_2), .sram_wdata(sram_wdata_2),
        .sram_re(sram_re_2), .sram_we(sram_we_2), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .hit_count(hit_count_2), .miss_count(miss_count_2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int unsigned sat(input int unsigned n, input int w);
        int unsigned mx;
        mx = (32'd1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // One CPU transaction; lat = SRAM wait cycles before sram_ready, gap = idle cycle afterwards.
    task automatic drive_txn(input logic rd, input logic wr, input logic hit, input logic [31:0] addr,
                             input logic [31:0] wd, input int lat, input logic [63:0] line, input bit gap);
        logic [31:0] crd, off, exp_rd;
        logic [16:0] exp_ca;
        logic [5:0]  exp_s;
        int          stalls, we_cnt, inv_cnt, k;
        bit          done, miss;
        crd    = $urandom;
        off    = addr - BASE;
        exp_ca = off[18:2];
        exp_rd = addr[2] ? line[63:32] : line[31:0];
        miss   = !wr && rd && !hit;
        done   = 0; stalls = 0; we_cnt = 0; inv_cnt = 0;
        MEM_R_EN = rd; MEM_W_EN = wr; address = addr; wdata = wd;
        cache_hit = hit; cache_rdata = crd; sram_ready = 1'b0; sram_rdata = {$urandom, $urandom};
        @(negedge clk);
        if (wr)       exp_s = 6'b000100;
        else if (hit) exp_s = 6'b110000;
        else          exp_s = 6'b000000;
        n_chk++; if (strb !== exp_s) begin n_fail++; $display("FAIL issue_strobes: got %b want %b", strb, exp_s); end
        n_chk++; if (cache_address !== exp_ca) begin n_fail++; $display("FAIL issue_cache_addr: got %h want %h", cache_address, exp_ca); end
        if (!wr && hit) begin
            n_chk++; if (rdata !== crd) begin n_fail++; $display("FAIL hit_rdata: got %h want %h", rdata, crd); end
            m_hits++; done = 1;
        end
        if (miss) m_miss++;
        stalls += !ready; inv_cnt += cache_invalidate; we_cnt += cache_we;
        k = 0;
        while (!done) begin
            @(posedge clk); #1;
            cache_hit = $urandom;
            sram_ready = (k == lat);
            sram_rdata = (k == lat) ? line : {$urandom, $urandom};
            @(negedge clk);
            if (wr) exp_s = (k == lat) ? 6'b100001 : 6'b000001;
            else    exp_s = (k == lat) ? 6'b101010 : 6'b000010;
            n_chk++; if (strb !== exp_s) begin n_fail++; $display("FAIL wait_strobes k=%0d: got %b want %b", k, strb, exp_s); end
            n_chk++; if (sram_address !== addr) begin n_fail++; $display("FAIL sram_address: got %h want %h", sram_address, addr); end
            n_chk++; if (cache_address !== exp_ca) begin n_fail++; $display("FAIL wait_cache_addr: got %h want %h", cache_address, exp_ca); end
            if (wr) begin
                n_chk++; if (sram_wdata !== wd) begin n_fail++; $display("FAIL sram_wdata: got %h want %h", sram_wdata, wd); end
            end else if (k == lat) begin
                n_chk++; if (cache_wdata !== line) begin n_fail++; $display("FAIL fill_line: got %h want %h", cache_wdata, line); end
                n_chk++; if (rdata !== exp_rd) begin n_fail++; $display("FAIL fill_rdata: got %h want %h", rdata, exp_rd); end
            end
            stalls += !ready; inv_cnt += cache_invalidate; we_cnt += cache_we;
            if (k == lat) done = 1;
            k++;
        end
        n_chk++; if (stalls != ((!wr && hit) ? 0 : 1 + lat)) begin n_fail++; $display("FAIL stall_cycles: got %0d want %0d", stalls, (!wr && hit) ? 0 : 1 + lat); end
        n_chk++; if (inv_cnt != (wr ? 1 : 0)) begin n_fail++; $display("FAIL invalidate_pulses: got %0d want %0d", inv_cnt, wr ? 1 : 0); end
        n_chk++; if (we_cnt != (miss ? 1 : 0)) begin n_fail++; $display("FAIL cache_we_pulses: got %0d want %0d", we_cnt, miss ? 1 : 0); end
        @(posedge clk); #1;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0; cache_hit = 1'b0;
        if (gap) begin
            @(negedge clk);
            n_chk++; if (strb !== 6'b100000 || rdata !== 32'd0) begin n_fail++; $display("FAIL idle_outputs: got %b/%h want 100000/0", strb, rdata); end
            n_chk++; if (hit_count !== 16'(sat(m_hits, 16)) || miss_count !== 16'(sat(m_miss, 16))) begin
                n_fail++; $display("FAIL counters: got %0d/%0d want %0d/%0d", hit_count, miss_count, sat(m_hits, 16), sat(m_miss, 16)); end
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        m_hits = 0; m_miss = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; MEM_R_EN = 1'b1; MEM_W_EN = 1'b1; cache_hit = 1'b1; cache_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++; if (strb !== 6'b100000) begin n_fail++; $display("FAIL reset_strobes: got %b want 100000", strb); end
        n_chk++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_chk++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_count, miss_count); end
        @(posedge clk); #1;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; cache_hit = 1'b0;
        rst = 1'b1; m_hits = 0; m_miss = 0;
        @(negedge clk);
        n_chk++; if (strb !== 6'b100000 || rdata !== 32'd0) begin n_fail++; $display("FAIL idle_after_reset: got %b/%h want 100000/0", strb, rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_read_miss_hit();
        drive_txn(1'b1, 1'b0, 1'b0, 32'h0000_0408, 32'h0, 3, 64'hBBBB_0002_AAAA_0001, 1'b1);
        drive_txn(1'b1, 1'b0, 1'b1, 32'h0000_0408, 32'h0, 0, 64'h0, 1'b1);
        n_chk++; if (hit_count !== 16'd1 || miss_count !== 16'd1) begin n_fail++; $display("FAIL miss_then_hit_counts: got %0d/%0d want 1/1", hit_count, miss_count); end
        drive_txn(1'b1, 1'b0, 1'b0, 32'h0000_0404, 32'h0, 1, 64'h1111_2222_3333_4444, 1'b1);
    endtask

    task automatic test_store();
        drive_txn(1'b0, 1'b1, 1'b0, 32'h0000_040C, 32'h1234_5678, 2, 64'h0, 1'b1);
    endtask

    task automatic test_rw_priority();
        logic [15:0] h0, m0;
        h0 = hit_count; m0 = miss_count;
        drive_txn(1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'hCAFE_F00D, 1, 64'h0, 1'b1);
        drive_txn(1'b1, 1'b1, 1'b0, 32'h0000_0504, 32'h0BAD_CAFE, 0, 64'h0, 1'b1);
        n_chk++; if (hit_count !== h0 || miss_count !== m0) begin n_fail++; $display("FAIL rw_priority_counts: got %0d/%0d want %0d/%0d", hit_count, miss_count, h0, m0); end
    endtask

    task automatic test_reset_in_fill();
        MEM_R_EN = 1'b1; address = 32'h0000_0600; cache_hit = 1'b0;
        @(negedge clk);
        n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rif_issue_ready: got %b want 0", ready); end
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++; if (strb !== 6'b000010) begin n_fail++; $display("FAIL rif_fill_strobes: got %b want 000010", strb); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (strb !== 6'b100000) begin n_fail++; $display("FAIL rif_during_reset: got %b want 100000", strb); end
        @(posedge clk); #1;
        rst = 1'b1; MEM_R_EN = 1'b0; m_hits = 0; m_miss = 0;
        sram_ready = 1'b1; sram_rdata = 64'h5555_6666_7777_8888;
        @(negedge clk);
        n_chk++; if (strb !== 6'b100000 || rdata !== 32'd0) begin n_fail++; $display("FAIL rif_late_sram_ready: got %b/%h want 100000/0", strb, rdata); end
        n_chk++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin n_fail++; $display("FAIL rif_counters: got %0d/%0d want 0/0", hit_count, miss_count); end
        @(posedge clk); #1;
        sram_ready = 1'b0;
        @(negedge clk);
        n_chk++; if (strb !== 6'b100000) begin n_fail++; $display("FAIL rif_idle: got %b want 100000", strb); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 5; i++)
            drive_txn(1'b1, 1'b0, 1'b1, BASE + 32'($urandom_range(0, 4095)), 32'h0, 0, 64'h0, 1'b0);
        @(negedge clk);
        n_chk++; if (hit_count_2 !== 2'd3) begin n_fail++; $display("FAIL sat_hit_w2: got %0d want 3", hit_count_2); end
        n_chk++; if (miss_count_2 !== 2'd0) begin n_fail++; $display("FAIL sat_miss_w2: got %0d want 0", miss_count_2); end
        n_chk++; if (hit_count !== 16'd5) begin n_fail++; $display("FAIL sat_hit_w16: got %0d want 5", hit_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int          kind;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            a    = (i % 4 == 0) ? 32'($urandom) : BASE + 32'($urandom_range(0, 32'h7FFFF));
            drive_txn(kind != 2, kind >= 2, kind == 0 || (kind == 3 && $urandom_range(0, 1) == 1), a,
                      $urandom, $urandom_range(0, 4), {$urandom, $urandom}, $urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        n_chk++; if (hit_count !== 16'(sat(m_hits, 16)) || miss_count !== 16'(sat(m_miss, 16))) begin
            n_fail++; $display("FAIL b2b_counters: got %0d/%0d want %0d/%0d", hit_count, miss_count, sat(m_hits, 16), sat(m_miss, 16)); end
        n_chk++; if (hit_count_2 !== 2'(sat(m_hits, 2)) || miss_count_2 !== 2'(sat(m_miss, 2))) begin
            n_fail++; $display("FAIL b2b_counters_w2: got %0d/%0d want %0d/%0d", hit_count_2, miss_count_2, sat(m_hits, 2), sat(m_miss, 2)); end
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        test_reset();
        test_read_miss_hit();
        test_store();
        test_rw_priority();
        test_reset_in_fill();
        test_saturation();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
